pe2ddr_wb: RTL and testbench

PE2DDR_WB -- requirements
Module: pe2ddr_wb

---
 rtl/pe2ddr_wb.sv | 207 ++++++++++++++++++++
 tb/tb_pe2ddr_wb.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe2ddr_wb.sv
// pe2ddr_wb: streams words from one selected PE buffer into a DDR write channel
// (address bursts + data beats). Define PE2DDR_LAST_EN to build ddr_last generation.
module pe2ddr_wb #(
    parameter int BUF_DEPTH  = 256,
    parameter int PE_NUM     = 32,
    parameter int ADDR_W     = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1,
    parameter int DDR_W      = 64,
    parameter int DDR_ADDR_W = 32,
    parameter int BURST_W    = 8,
    parameter int PE_W       = (PE_NUM > 1) ? $clog2(PE_NUM) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    output logic                      done,
    input  logic [PE_W-1:0]           conf_pe_sel,
    input  logic [ADDR_W-1:0]         conf_buf_addr,
    input  logic [DDR_ADDR_W-1:0]     conf_st_addr,
    input  logic [DDR_ADDR_W-1:0]     conf_step,
    input  logic [BURST_W-1:0]        conf_burst,
    input  logic [BURST_W-1:0]        conf_burst_num,
    output logic [ADDR_W-1:0]         buf_rd_addr,
    output logic [PE_NUM-1:0]         buf_rd_en,
    input  logic [PE_NUM*DDR_W-1:0]   buf_rd_data,
    output logic [DDR_ADDR_W-1:0]     ddr_addr,
    output logic [BURST_W-1:0]        ddr_size,
    output logic                      ddr_addr_valid,
    input  logic                      ddr_addr_ready,
    output logic [DDR_W-1:0]          ddr_data,
    output logic                      ddr_last,
    output logic                      ddr_valid,
    input  logic                      ddr_ready
);

    localparam int CNT_W = 2 * BURST_W;

    typedef enum logic {IDLE, RUN} state_t;

    state_t                  r_state;
    logic [PE_W-1:0]         r_pe_sel;
    logic [DDR_ADDR_W-1:0]   r_step;
    logic [ADDR_W-1:0]       r_rd_addr;
    logic [CNT_W-1:0]        r_rd_left;
    logic [CNT_W-1:0]        r_beat_left;
    logic [BURST_W-1:0]      r_addr_left;
    logic [DDR_ADDR_W-1:0]   r_ddr_addr;
    logic [BURST_W-1:0]      r_ddr_size;
    logic                    r_addr_valid;
    logic                    r_done;
    logic                    r_rd_pend;
    logic [DDR_W-1:0]        r_fifo [2];
    logic                    r_wr_ptr;
    logic                    r_rd_ptr;
    logic [1:0]              r_count;

    logic                    w_pop;
    logic                    w_addr_hs;
    logic [2:0]              w_budget;
    logic                    w_rd_en;
    logic [ADDR_W-1:0]       w_rd_addr_nxt;
    logic [CNT_W-1:0]        w_total;
    logic                    w_addr_fin;
    logic                    w_data_fin;
    logic [DDR_W-1:0]        w_rd_word;

    assign w_pop     = (r_count != 2'd0) && ddr_ready;
    assign w_addr_hs = r_addr_valid && ddr_addr_ready;

    // Slots the FIFO will hold after this cycle: the beat leaving now frees its
    // entry in time for a read issued now, which keeps one beat per cycle.
    assign w_budget = 3'(r_count) + 3'(r_rd_pend) - 3'(w_pop);
    assign w_rd_en  = (r_state == RUN) && (r_rd_left != '0) && (w_budget < 3'd2);

    assign w_rd_addr_nxt = (r_rd_addr == ADDR_W'(BUF_DEPTH - 1)) ? '0 : r_rd_addr + ADDR_W'(1);
    assign w_total       = CNT_W'(conf_burst) * CNT_W'(conf_burst_num);

    assign w_addr_fin = (r_addr_left == '0) || ((r_addr_left == BURST_W'(1)) && w_addr_hs);
    assign w_data_fin = (r_beat_left == '0) || ((r_beat_left == CNT_W'(1)) && w_pop);

    always_comb begin
        w_rd_word = '0;
        for (int p = 0; p < PE_NUM; p++) begin
            if (r_pe_sel == PE_W'(p)) begin
                w_rd_word = buf_rd_data[p*DDR_W +: DDR_W];
            end
        end
    end

    // Job control: the address channel and the read/beat counters run independently.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_pe_sel     <= '0;
            r_step       <= '0;
            r_rd_addr    <= '0;
            r_rd_left    <= '0;
            r_beat_left  <= '0;
            r_addr_left  <= '0;
            r_ddr_addr   <= '0;
            r_ddr_size   <= '0;
            r_addr_valid <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_pe_sel    <= conf_pe_sel;
                        r_step      <= conf_step;
                        r_rd_addr   <= conf_buf_addr;
                        r_rd_left   <= w_total;
                        r_beat_left <= w_total;
                        r_addr_left <= conf_burst_num;
                        r_ddr_addr  <= conf_st_addr;
                        r_ddr_size  <= conf_burst;
                        if (conf_burst_num == '0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_addr_valid <= 1'b1;
                            r_state      <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (w_rd_en) begin
                        r_rd_addr <= w_rd_addr_nxt;
                        r_rd_left <= r_rd_left - CNT_W'(1);
                    end
                    if (w_pop) begin
                        r_beat_left <= r_beat_left - CNT_W'(1);
                    end
                    if (w_addr_hs) begin
                        r_addr_left <= r_addr_left - BURST_W'(1);
                        if (r_addr_left == BURST_W'(1)) begin
                            r_addr_valid <= 1'b0;
                        end else begin
                            r_ddr_addr <= r_ddr_addr + r_step;
                        end
                    end
                    if (w_addr_fin && w_data_fin) begin
                        r_done  <= 1'b1;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Two-entry skid FIFO between the one-cycle buffer read and the DDR data port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_pend <= 1'b0;
            r_fifo[0] <= '0;
            r_fifo[1] <= '0;
            r_wr_ptr  <= 1'b0;
            r_rd_ptr  <= 1'b0;
            r_count   <= 2'd0;
        end else begin
            r_rd_pend <= w_rd_en;
            if (r_rd_pend) begin
                r_fifo[r_wr_ptr] <= w_rd_word;
                r_wr_ptr         <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({r_rd_pend, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef PE2DDR_LAST_EN
    logic [BURST_W-1:0] r_beat_in_burst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_beat_in_burst <= '0;
        end else if ((r_state == IDLE) && start) begin
            r_beat_in_burst <= '0;
        end else if (w_pop) begin
            if (r_beat_in_burst == r_ddr_size - BURST_W'(1)) begin
                r_beat_in_burst <= '0;
            end else begin
                r_beat_in_burst <= r_beat_in_burst + BURST_W'(1);
            end
        end
    end

    assign ddr_last = (r_count != 2'd0) && (r_beat_in_burst == r_ddr_size - BURST_W'(1));
`else
    assign ddr_last = 1'b0;
`endif

    assign done           = r_done;
    assign buf_rd_addr    = r_rd_addr;
    assign buf_rd_en      = w_rd_en ? (PE_NUM'(1) << r_pe_sel) : '0;
    assign ddr_addr       = r_ddr_addr;
    assign ddr_size       = r_ddr_size;
    assign ddr_addr_valid = r_addr_valid;
    assign ddr_data       = r_fifo[r_rd_ptr];
    assign ddr_valid      = (r_count != 2'd0);

endmodule

// File: tb/tb_pe2ddr_wb.sv
// Testbench for pe2ddr_wb: table-driven jobs, corner sequences and random jobs
// checked against a queue-based model of the expected address and data streams.
module tb_pe2ddr_wb;

   localparam int BUF_DEPTH  = 256;
   localparam int PE_NUM     = 32;
   localparam int ADDR_W     = 8;
   localparam int DDR_W      = 64;
   localparam int DDR_ADDR_W = 32;
   localparam int BURST_W    = 8;
   localparam int PE_W       = 5;

   logic                    clock = 1'b0;
   logic                    rst;
   logic                    start;
   logic                    done;
   logic [PE_W-1:0]         confPeSel;
   logic [ADDR_W-1:0]       confBufAddr;
   logic [DDR_ADDR_W-1:0]   confStAddr;
   logic [DDR_ADDR_W-1:0]   confStep;
   logic [BURST_W-1:0]      confBurst;
   logic [BURST_W-1:0]      confBurstNum;
   logic [ADDR_W-1:0]       bufRdAddr;
   logic [PE_NUM-1:0]       bufRdEn;
   logic [PE_NUM*DDR_W-1:0] bufRdData;
   logic [DDR_ADDR_W-1:0]   ddrAddr;
   logic [BURST_W-1:0]      ddrSize;
   logic                    ddrAddrValid;
   logic                    ddrAddrReady;
   logic [DDR_W-1:0]        ddrData;
   logic                    ddrLast;
   logic                    ddrValid;
   logic                    ddrReady;

   logic [DDR_W-1:0]        bufData [PE_NUM];

   int vectors = 0;
   int miscompares = 0;

   typedef struct {
      int          pe;
      int          bufAddr;
      logic [31:0] stAddr;
      logic [31:0] step;
      int          burst;
      int          burstNum;
      int          mode;
      int          expBeats;
      int          expReqs;
      int          expFinalRd;
   } vec_t;

   vec_t tbl [6];

   pe2ddr_wb #(
      .BUF_DEPTH(BUF_DEPTH), .PE_NUM(PE_NUM), .ADDR_W(ADDR_W), .DDR_W(DDR_W),
      .DDR_ADDR_W(DDR_ADDR_W), .BURST_W(BURST_W), .PE_W(PE_W)
   ) dut (
      .clk(clock), .rst(rst), .start(start), .done(done),
      .conf_pe_sel(confPeSel), .conf_buf_addr(confBufAddr), .conf_st_addr(confStAddr),
      .conf_step(confStep), .conf_burst(confBurst), .conf_burst_num(confBurstNum),
      .buf_rd_addr(bufRdAddr), .buf_rd_en(bufRdEn), .buf_rd_data(bufRdData),
      .ddr_addr(ddrAddr), .ddr_size(ddrSize), .ddr_addr_valid(ddrAddrValid),
      .ddr_addr_ready(ddrAddrReady), .ddr_data(ddrData), .ddr_last(ddrLast),
      .ddr_valid(ddrValid), .ddr_ready(ddrReady)
   );

   always #5 clock = ~clock;

   // Content of word addr in PE pe's buffer; unique per (pe, addr).
   function automatic logic [63:0] word(input int pe, input int addr);
      return {8'hC0 ^ 8'(pe), 8'(pe), 16'(addr), (32'(addr) * 32'h9E3779B1) ^ 32'(pe)};
   endfunction

   // PE buffers answer one cycle after a read enable; otherwise the bus carries junk.
   always @(posedge clock) begin
      for (int p = 0; p < PE_NUM; p++) begin
         bufData[p] <= bufRdEn[p] ? word(p, int'(bufRdAddr)) : {$urandom, $urandom};
      end
   end

   always_comb begin
      bufRdData = '0;
      for (int p = 0; p < PE_NUM; p++) begin
         bufRdData[p*DDR_W +: DDR_W] = bufData[p];
      end
   end

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic driveConf(input vec_t v);
      confPeSel    = PE_W'(v.pe);
      confBufAddr  = ADDR_W'(v.bufAddr);
      confStAddr   = v.stAddr;
      confStep     = v.step;
      confBurst    = BURST_W'(v.burst);
      confBurstNum = BURST_W'(v.burstNum);
   endtask

   task automatic driveJunk();
      confPeSel    = PE_W'($urandom);
      confBufAddr  = ADDR_W'($urandom);
      confStAddr   = $urandom;
      confStep     = $urandom;
      confBurst    = BURST_W'($urandom_range(1, 9));
      confBurstNum = BURST_W'($urandom_range(0, 3));
   endtask

   task automatic setReady(input int mode, input int cyc);
      case (mode)
         0: begin ddrAddrReady = 1'b1; ddrReady = 1'b1; end
         1: begin ddrAddrReady = 1'b1; ddrReady = (cyc % 2 == 1); end
         default: begin
            ddrAddrReady = ($urandom_range(0, 3) != 0);
            ddrReady     = ($urandom_range(0, 3) != 0);
         end
      endcase
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, " done"}, 64'(done), 64'(0));
      checkOutput({tag, " buf_rd_en"}, 64'(bufRdEn), 64'(0));
      checkOutput({tag, " ddr_addr_valid"}, 64'(ddrAddrValid), 64'(0));
      checkOutput({tag, " ddr_valid"}, 64'(ddrValid), 64'(0));
      checkOutput({tag, " ddr_last"}, 64'(ddrLast), 64'(0));
      checkOutput({tag, " buf_rd_addr"}, 64'(bufRdAddr), 64'(0));
      checkOutput({tag, " ddr_addr"}, 64'(ddrAddr), 64'(0));
      checkOutput({tag, " ddr_size"}, 64'(ddrSize), 64'(0));
      checkOutput({tag, " ddr_data"}, ddrData, 64'(0));
   endtask

   // Runs one job from a posedge+1 entry point and returns at posedge+1.
   // rstAfterBeats >= 0 aborts the job with a reset once that many beats have moved.
   task automatic applyStimulus(input vec_t v, input bit pokeStart, input int rstAfterBeats);
      logic [63:0] expData [$];
      logic [31:0] expAddr [$];
      logic [63:0] expWord;
      logic [31:0] expA;
      logic [63:0] prevData;
      logic [31:0] prevAddr;
      logic        expLast;
      int total, cyc, beats, reqs, reads, firstValid, lastAHs, lastDHs, lastRd, doneCyc;
      bit finished, aborted, prevStall, prevAStall;

      total = v.burst * v.burstNum;
      for (int i = 0; i < total; i++) expData.push_back(word(v.pe, (v.bufAddr + i) % BUF_DEPTH));
      for (int k = 0; k < v.burstNum; k++) expAddr.push_back(v.stAddr + 32'(k) * v.step);
      cyc = 0; beats = 0; reqs = 0; reads = 0; firstValid = -1;
      lastAHs = 0; lastDHs = 0; lastRd = -1; doneCyc = 0;
      finished = 1'b0; aborted = 1'b0; prevStall = 1'b0; prevAStall = 1'b0;
      prevData = '0; prevAddr = '0;

      driveConf(v);
      start = 1'b1;
      setReady(v.mode, 0);
      @(posedge clock); #1;
      start = 1'b0;
      driveJunk();

      while (!finished && !aborted && cyc < 2000) begin
         cyc++;
         setReady(v.mode, cyc);
         start = pokeStart && (cyc == 2);
         @(negedge clock);
         if (bufRdEn != '0) begin
            checkOutput("rd_en select", 64'(bufRdEn), 64'(32'd1 << v.pe));
            checkOutput("rd_addr", 64'(bufRdAddr), 64'((v.bufAddr + reads) % BUF_DEPTH));
            lastRd = int'(bufRdAddr);
            reads++;
         end
         if (prevStall)
            checkOutput("data hold", {ddrValid, ddrData[62:0]}, {1'b1, prevData[62:0]});
         if (prevAStall)
            checkOutput("addr hold", {ddrAddrValid, 31'(0), ddrAddr}, {1'b1, 31'(0), prevAddr});
         if (ddrAddrValid && ddrAddrReady) begin
            if (expAddr.size() == 0) begin
               checkOutput("extra addr request", 64'(ddrAddr), 64'(0) - 64'(1));
            end else begin
               expA = expAddr.pop_front();
               checkOutput("ddr_addr", 64'(ddrAddr), 64'(expA));
               checkOutput("ddr_size", 64'(ddrSize), 64'(v.burst));
            end
            reqs++;
            lastAHs = cyc;
         end
         if (ddrValid && firstValid < 0) firstValid = cyc;
         if (ddrValid && ddrReady) begin
            if (expData.size() == 0) begin
               checkOutput("extra data beat", ddrData, 64'(0) - 64'(1));
            end else begin
               expWord = expData.pop_front();
               checkOutput("ddr_data", ddrData, expWord);
`ifdef PE2DDR_LAST_EN
               expLast = (beats % v.burst) == (v.burst - 1);
`else
               expLast = 1'b0;
`endif
               checkOutput("ddr_last", 64'(ddrLast), 64'(expLast));
            end
            beats++;
            lastDHs = cyc;
         end
         prevStall  = ddrValid && !ddrReady;
         prevData   = ddrData;
         prevAStall = ddrAddrValid && !ddrAddrReady;
         prevAddr   = ddrAddr;
         if (done) begin
            finished = 1'b1;
            doneCyc  = cyc;
         end
         if (rstAfterBeats >= 0 && beats == rstAfterBeats && !finished) begin
            @(posedge clock); #1;
            rst = 1'b1;
            #1;
            checkAllZero("mid-job reset");
            repeat (2) @(posedge clock);
            #1;
            rst = 1'b0;
            for (int i = 0; i < 6; i++) begin
               @(negedge clock);
               checkOutput("no done after reset", 64'({done, ddrValid, ddrAddrValid, |bufRdEn}), 64'(0));
            end
            aborted = 1'b1;
         end
         @(posedge clock); #1;
      end

      if (!aborted) begin
         if (!finished) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL done timeout: got no done in %0d cycles, expected done", cyc);
         end else begin
            checkOutput("done cycle", 64'(doneCyc), 64'(((lastAHs > lastDHs) ? lastAHs : lastDHs) + 1));
            checkOutput("beat count", 64'(beats), 64'(v.expBeats));
            checkOutput("request count", 64'(reqs), 64'(v.expReqs));
            checkOutput("read count", 64'(reads), 64'(v.expBeats));
            if (v.expFinalRd >= 0) checkOutput("final rd addr", 64'(lastRd), 64'(v.expFinalRd));
            // ddr_valid rises on the second edge after the edge that accepted start
            if (total > 0) checkOutput("first valid cycle", 64'(firstValid), 64'(3));
            if (total > 0 && v.mode == 0) checkOutput("full-rate last beat", 64'(lastDHs), 64'(total + 2));
            @(negedge clock);
            checkOutput("done single pulse", 64'({done, ddrValid, ddrAddrValid, |bufRdEn}), 64'(0));
            @(posedge clock); #1;
         end
      end
   endtask

   initial begin
      vec_t r;
      rst          = 1'b1;
      start        = 1'b0;
      ddrAddrReady = 1'b1;
      ddrReady     = 1'b1;
      driveJunk();
      repeat (3) @(posedge clock);
      #1;
      checkAllZero("reset");
      rst = 1'b0;
      @(posedge clock); #1;

      // pe, bufAddr, stAddr, step, burst, burstNum, mode, expBeats, expReqs, expFinalRd
      tbl[0] = '{3,   0, 32'h0000_1000, 32'h40,  4, 2, 0, 8, 2,   7};
      tbl[1] = '{3,   0, 32'h0000_1000, 32'h40,  4, 2, 1, 8, 2,   7};
      tbl[2] = '{5, 254, 32'h0000_0020, 32'h10,  4, 1, 0, 4, 1,   1};
      tbl[3] = '{0,  10, 32'h0000_0000, 32'h0,   1, 0, 0, 0, 0,  -1};
      tbl[4] = '{31, 250, 32'hFFFF_FFF0, 32'h10, 3, 3, 2, 9, 3,   2};
      tbl[5] = '{7, 100, 32'h0000_0500, 32'h100, 1, 5, 1, 5, 5, 104};

      for (int i = 0; i < 6; i++) begin
         $display("[TB] table job %0d", i);
         applyStimulus(tbl[i], 1'b0, -1);
      end

      $display("[TB] start pulse while running");
      applyStimulus(tbl[0], 1'b1, -1);

      $display("[TB] reset after three beats, then rerun");
      applyStimulus(tbl[0], 1'b0, 3);
      applyStimulus(tbl[0], 1'b0, -1);

      for (int n = 0; n < 20; n++) begin
         r.pe         = $urandom_range(0, PE_NUM - 1);
         r.bufAddr    = $urandom_range(0, BUF_DEPTH - 1);
         r.stAddr     = $urandom;
         r.step       = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 255)) << 4;
         r.burst      = $urandom_range(1, 6);
         r.burstNum   = $urandom_range(0, 4);
         r.mode       = $urandom_range(0, 2);
         r.expBeats   = r.burst * r.burstNum;
         r.expReqs    = r.burstNum;
         r.expFinalRd = (r.expBeats > 0) ? (r.bufAddr + r.expBeats - 1) % BUF_DEPTH : -1;
         applyStimulus(r, ($urandom_range(0, 1) == 1) && (r.burstNum > 0), -1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
